// File: rtl/macrow4_pkg.sv
// Shared widths, FSM state encoding and lane helper
// for the macrow4 initiator-side sequencer.
package macrow4_pkg;

    localparam int FP_W  = 16;
    localparam int LANES = 4;
    localparam int VEC_W = FP_W * LANES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADW,
        ST_GAP,
        ST_STREAM,
        ST_DRAIN
    } state_e;

    // Lane k of a packed FP16 vector; lane 0 is the low word.
    function automatic logic [FP_W-1:0] lane(
        input logic [VEC_W-1:0] v,
        input logic [1:0]       k
    );
        return v[FP_W*int'(k) +: FP_W];
    endfunction

endpackage

// File: rtl/macrow4_seq_if.sv
// Data-mover side handshakes of the macrow4 sequencer:
// weight vectors, X vectors and the result stream.
interface macrow4_seq_if;
    import macrow4_pkg::*;

    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [VEC_W-1:0] w_vec_i;
    logic             x_valid_i;
    logic             x_ready_o;
    logic [VEC_W-1:0] x_vec_i;
    logic             y_valid_o;
    logic             y_ready_i;
    logic [FP_W-1:0]  y_o;

    modport master (
        output cfg_valid_i, w_vec_i,
        output x_valid_i, x_vec_i,
        output y_ready_i,
        input  cfg_ready_o, x_ready_o,
        input  y_valid_o, y_o
    );

    modport slave (
        input  cfg_valid_i, w_vec_i,
        input  x_valid_i, x_vec_i,
        input  y_ready_i,
        output cfg_ready_o, x_ready_o,
        output y_valid_o, y_o
    );

endinterface

// File: rtl/macrow4_resfifo.sv
// First-word-fall-through result FIFO; push into a
// full FIFO and pop from an empty one are ignored.
module macrow4_resfifo
    import macrow4_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic [FP_W-1:0] din,
    input  logic            pop,
    output logic [FP_W-1:0] dout,
    output logic            empty,
    output logic            full,
    output logic [CW-1:0]   count
);

    logic [FP_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wp_q, rp_q;
    logic            do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rp_q];

    // Storage array; contents are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp_q] <= din;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            count <= '0;
        end else begin
            if (do_push) wp_q <= nxt(wp_q);
            if (do_pop)  rp_q <= nxt(rp_q);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/macrow4_seq.sv
// Serialises weight and X vectors onto the macrow4
// load ports and collects results under a credit limit.
module macrow4_seq
    import macrow4_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    macrow4_seq_if.slave    bus,
    output logic [3:0]      enW_o,
    output logic [FP_W-1:0] W_o,
    output logic            enX_o,
    output logic [FP_W-1:0] X_o,
    input  logic            mac_valid_i,
    input  logic [FP_W-1:0] mac_y_i,
    output logic            err_o
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e           state_q, state_d;
    logic [1:0]       cnt_q;
    logic [VEC_W-1:0] w_q, x_q;
    logic             loaded_q, err_q;
    logic [CW-1:0]    credit_q, fifo_count, pending;
    logic             idle, last, cfg_hs, x_hs, y_hs;
    logic             push, fifo_empty, fifo_full;

    // Results not yet returned = issued-not-popped minus queued.
    assign pending = credit_q - fifo_count;
    assign idle    = (state_q == ST_IDLE);
    assign last    = (cnt_q == 2'd3);

    // A pending reconfiguration takes priority over new X vectors.
    assign bus.cfg_ready_o = idle && (pending == '0);
    assign bus.x_ready_o   = loaded_q && !bus.cfg_valid_i
                          && (credit_q < CW'(DEPTH))
                          && (idle || (state_q == ST_STREAM && last));

    assign cfg_hs = bus.cfg_valid_i && bus.cfg_ready_o;
    assign x_hs   = bus.x_valid_i && bus.x_ready_o;
    assign y_hs   = bus.y_valid_o && bus.y_ready_i;
    assign push   = mac_valid_i && (pending != '0) && !fifo_full;
    assign err_o  = err_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_hs)                state_d = ST_LOADW;
                else if (bus.cfg_valid_i)  state_d = ST_DRAIN;
                else if (x_hs)             state_d = ST_STREAM;
            end
            ST_LOADW:  if (last) state_d = ST_GAP;
            ST_GAP:    state_d = ST_IDLE;
            ST_STREAM: if (last) state_d = x_hs ? ST_STREAM : ST_IDLE;
            ST_DRAIN:  if (pending == '0) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Lane counter, vector registers, credit and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            w_q      <= '0;
            x_q      <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            credit_q <= '0;
        end else begin
            if (state_q == ST_LOADW || state_q == ST_STREAM)
                cnt_q <= cnt_q + 2'd1;
            else
                cnt_q <= '0;
            if (cfg_hs) w_q <= bus.w_vec_i;
            if (x_hs)   x_q <= bus.x_vec_i;
            if (state_q == ST_LOADW && last) loaded_q <= 1'b1;
            if (mac_valid_i && pending == '0) err_q <= 1'b1;
            unique case ({x_hs, y_hs})
                2'b10:   credit_q <= credit_q + CW'(1);
                2'b01:   credit_q <= credit_q - CW'(1);
                default: credit_q <= credit_q;
            endcase
        end
    end

    // MAC load-port drive; idle ports stay at zero.
    always_comb begin
        enW_o = '0;
        W_o   = '0;
        enX_o = 1'b0;
        X_o   = '0;
        if (state_q == ST_LOADW) begin
            enW_o = 4'b0001 << cnt_q;
            W_o   = lane(w_q, cnt_q);
        end
        if (state_q == ST_STREAM) begin
            enX_o = 1'b1;
            X_o   = lane(x_q, cnt_q);
        end
    end

    macrow4_resfifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (mac_y_i),
        .pop     (bus.y_ready_i),
        .dout    (bus.y_o),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign bus.y_valid_o = !fifo_empty;

endmodule

// File: tb/tb_macrow4_seq.sv
// Cycle-by-cycle directed bench for macrow4_seq:
// a per-cycle vector table plus reset/reload sequences.
module tb_macrow4_seq;
    import macrow4_pkg::*;

    localparam logic [63:0] W1  = {4{16'h8055}};
    localparam logic [63:0] W2  = 64'h4444_3333_2222_1111;
    localparam logic [63:0] XA  = {4{16'h3155}};
    localparam logic [63:0] XB  = {4{16'h6473}};
    localparam logic [63:0] XC  = {4{16'h1111}};
    localparam logic [63:0] Z   = 64'h0;
    localparam bit          H   = 1'b1;
    localparam bit          L   = 1'b0;
    localparam int          NV  = 39;

    typedef struct {
        bit          cv;
        logic [63:0] w;
        bit          xv;
        logic [63:0] x;
        bit          mv;
        logic [15:0] my;
        bit          yr;
        logic [3:0]  enw;
        logic [15:0] wo;
        bit          enx;
        logic [15:0] xo;
        bit          cr;
        bit          xr;
        bit          yv;
        logic [15:0] yo;
        bit          er;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [3:0]      enW_o;
    logic [15:0]     W_o;
    logic            enX_o;
    logic [15:0]     X_o;
    logic            mac_valid_i = 1'b0;
    logic [15:0]     mac_y_i = '0;
    logic            err_o;
    int              tests = 0;
    int              fails = 0;
    vec_t            tbl [NV];

    macrow4_seq_if bus ();

    macrow4_seq #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .enW_o       (enW_o),
        .W_o         (W_o),
        .enX_o       (enX_o),
        .X_o         (X_o),
        .mac_valid_i (mac_valid_i),
        .mac_y_i     (mac_y_i),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input bit cv, input logic [63:0] w,
        input bit xv, input logic [63:0] x,
        input bit mv, input logic [15:0] my, input bit yr,
        input logic [3:0] enw, input logic [15:0] wo,
        input bit enx, input logic [15:0] xo,
        input bit cr, input bit xr, input bit yv,
        input logic [15:0] yo, input bit er
    );
        vec_t v;
        v.cv = cv; v.w = w; v.xv = xv; v.x = x;
        v.mv = mv; v.my = my; v.yr = yr;
        v.enw = enw; v.wo = wo; v.enx = enx; v.xo = xo;
        v.cr = cr; v.xr = xr; v.yv = yv; v.yo = yo; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [56:0] e);
        logic [56:0] a;
        a = {enW_o, W_o, enX_o, X_o, bus.cfg_ready_o,
             bus.x_ready_o, bus.y_valid_o, bus.y_o, err_o};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got enW=%b W=%h enX=%b X=%h crdy=%b xrdy=%b yv=%b y=%h err=%b want enW=%b W=%h enX=%b X=%h crdy=%b xrdy=%b yv=%b y=%h err=%b",
                     nm, a[56:53], a[52:37], a[36], a[35:20], a[19], a[18],
                     a[17], a[16:1], a[0], e[56:53], e[52:37], e[36],
                     e[35:20], e[19], e[18], e[17], e[16:1], e[0]);
        end
    endtask

    task automatic chk1(input string nm, input logic a, input logic e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b want %b", nm, a, e);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.cfg_valid_i = v.cv;
        bus.w_vec_i     = v.w;
        bus.x_valid_i   = v.xv;
        bus.x_vec_i     = v.x;
        bus.y_ready_i   = v.yr;
        mac_valid_i     = v.mv;
        mac_y_i         = v.my;
    endtask

    initial begin
        int seen;
        vec_t v;
        //            cv W  xv X  mv my       yr  enW   W        enX X        cr xr yv y        err
        tbl[0]  = mk(H, W1, L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    H, L, L, 16'h0,    L);
        tbl[1]  = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h1, 16'h8055, L, 16'h0,    L, L, L, 16'h0,    L);
        tbl[2]  = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h2, 16'h8055, L, 16'h0,    L, L, L, 16'h0,    L);
        tbl[3]  = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h4, 16'h8055, L, 16'h0,    L, L, L, 16'h0,    L);
        tbl[4]  = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h8, 16'h8055, L, 16'h0,    L, L, L, 16'h0,    L);
        tbl[5]  = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    L, L, L, 16'h0,    L);
        tbl[6]  = mk(L, Z,  H, XA, L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    H, H, L, 16'h0,    L);
        tbl[7]  = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h3155, L, L, L, 16'h0,    L);
        tbl[8]  = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h3155, L, L, L, 16'h0,    L);
        tbl[9]  = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h3155, L, L, L, 16'h0,    L);
        tbl[10] = mk(L, Z,  H, XB, L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h3155, L, H, L, 16'h0,    L);
        tbl[11] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h6473, L, L, L, 16'h0,    L);
        tbl[12] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h6473, L, L, L, 16'h0,    L);
        tbl[13] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h6473, L, L, L, 16'h0,    L);
        tbl[14] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h6473, L, L, L, 16'h0,    L);
        tbl[15] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    L, L, L, 16'h0,    L);
        tbl[16] = mk(L, Z,  L, Z,  H, 16'h1234, L, 4'h0, 16'h0,    L, 16'h0,    L, L, L, 16'h0,    L);
        tbl[17] = mk(L, Z,  L, Z,  H, 16'h5678, L, 4'h0, 16'h0,    L, 16'h0,    L, L, H, 16'h1234, L);
        tbl[18] = mk(L, Z,  H, XC, L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    H, L, H, 16'h1234, L);
        tbl[19] = mk(L, Z,  H, XC, L, 16'h0,    H, 4'h0, 16'h0,    L, 16'h0,    H, L, H, 16'h1234, L);
        tbl[20] = mk(L, Z,  H, XC, L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    H, H, H, 16'h5678, L);
        tbl[21] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h1111, L, L, H, 16'h5678, L);
        tbl[22] = mk(H, W2, L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h1111, L, L, H, 16'h5678, L);
        tbl[23] = mk(H, W2, L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h1111, L, L, H, 16'h5678, L);
        tbl[24] = mk(H, W2, L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    H, 16'h1111, L, L, H, 16'h5678, L);
        tbl[25] = mk(H, W2, L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    L, L, H, 16'h5678, L);
        tbl[26] = mk(H, W2, L, Z,  H, 16'h9abc, L, 4'h0, 16'h0,    L, 16'h0,    L, L, H, 16'h5678, L);
        tbl[27] = mk(H, W2, L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    L, L, H, 16'h5678, L);
        tbl[28] = mk(H, W2, L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    H, L, H, 16'h5678, L);
        tbl[29] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h1, 16'h1111, L, 16'h0,    L, L, H, 16'h5678, L);
        tbl[30] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h2, 16'h2222, L, 16'h0,    L, L, H, 16'h5678, L);
        tbl[31] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h4, 16'h3333, L, 16'h0,    L, L, H, 16'h5678, L);
        tbl[32] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h8, 16'h4444, L, 16'h0,    L, L, H, 16'h5678, L);
        tbl[33] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    L, L, H, 16'h5678, L);
        tbl[34] = mk(L, Z,  L, Z,  L, 16'h0,    H, 4'h0, 16'h0,    L, 16'h0,    H, L, H, 16'h5678, L);
        tbl[35] = mk(L, Z,  L, Z,  L, 16'h0,    H, 4'h0, 16'h0,    L, 16'h0,    H, H, H, 16'h9abc, L);
        tbl[36] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    H, H, L, 16'h0,    L);
        tbl[37] = mk(L, Z,  L, Z,  H, 16'h7777, L, 4'h0, 16'h0,    L, 16'h0,    H, H, L, 16'h0,    L);
        tbl[38] = mk(L, Z,  L, Z,  L, 16'h0,    L, 4'h0, 16'h0,    L, 16'h0,    H, H, L, 16'h0,    H);

        drive(mk(L, Z, L, Z, L, 16'h0, L, 4'h0, 16'h0, L, 16'h0, L, L, L, 16'h0, L));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 chk("reset_state", {4'h0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0});
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            v = tbl[i];
            drive(v);
            #1 chk($sformatf("row%0d", i),
                   {v.enw, v.wo, v.enx, v.xo, v.cr, v.xr, v.yv, v.yo, v.er});
        end

        // One more vector, then reset in its third stream cycle.
        @(negedge clk);
        drive(mk(L, Z, H, XA, L, 16'h0, L, 4'h0, 16'h0, L, 16'h0, L, L, L, 16'h0, L));
        #1 chk1("pre_reset_xrdy", bus.x_ready_o, 1'b1);
        @(negedge clk);
        bus.x_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk1("stream_k2_enx", enX_o, 1'b1);
        reset_n = 1'b0;
        #1 chk("async_reset", {4'h0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0});
        @(negedge clk);
        reset_n = 1'b1;
        bus.x_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk1($sformatf("unloaded_xrdy%0d", i), bus.x_ready_o, 1'b0);
        end

        // Reload weights; x_ready must return exactly 6 cycles later.
        @(negedge clk);
        bus.cfg_valid_i = 1'b1;
        bus.w_vec_i = W1;
        #1 chk1("reload_crdy", bus.cfg_ready_o, 1'b1);
        @(negedge clk);
        bus.cfg_valid_i = 1'b0;
        seen = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) @(negedge clk);
            #1;
            if (seen == 0 && bus.x_ready_o) seen = n;
        end
        tests++;
        if (seen != 6) begin
            fails++;
            $display("FAIL reload_xrdy_latency: got %0d want 6", seen);
        end
        bus.x_valid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/macrow4_seq.md
# macrow4_seq

Sequencer and result collector on the initiator side of `macrow4`. It accepts a packed 4-lane FP16 weight vector and packed 4-lane FP16 X vectors over valid/ready handshakes. It serialises them onto the `enW`/`W_i` and `enX`/`X_i` load ports, and captures each returned `Y_o` into a small result FIFO with its own valid/ready output. It sits between the system-level data mover and one `macrow4` instance, and shares that instance's clock and reset.

## Interface
- `DEPTH`, 2: result FIFO entries. This is also the maximum number of X vectors in flight (credit limit). Legal range 1–4.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_valid_i` / `cfg_ready_o`  in/out  1/1  weight-vector handshake.
- `w_vec_i`  in  64  four FP16 weights. Lane k is bits [16k+15:16k]; lane 0 is issued first.
- `x_valid_i` / `x_ready_o`  in/out  1/1  X-vector handshake.
- `x_vec_i`  in  64  four FP16 X elements, same lane order as `w_vec_i`.
- `enW_o`  out  4  one-hot weight-slot enable to MAC.
- `W_o`  out  16  weight data to MAC.
- `enX_o`  out  1  X enable to MAC.
- `X_o`  out  16  X data to MAC.
- `mac_valid_i`  in  1  result strobe from MAC. One pulse per 4-element X vector.
- `mac_y_i`  in  16  result from MAC.
- `y_valid_o` / `y_ready_i`  out/in  1/1  result handshake, first-word-fall-through.
- `y_o`  out  16  result data.
- `err_o`  out  1  sticky protocol error.

## Operation
- FSM states:
  - IDLE: `cfg_ready_o`=1. If weights are loaded and a credit is free, `x_ready_o`=1.
  - LOADW: 4 cycles.
  - GAP: 1 cycle, all enables 0.
  - STREAM: 4 cycles per vector.
  - DRAIN: entered when `cfg_valid_i` is asserted while vectors are outstanding.
- Transitions:
  - cfg handshake → LOADW → GAP → IDLE.
  - x handshake → STREAM. At the end of STREAM: go to STREAM again if another x handshake occurred on the last cycle, otherwise to IDLE.
  - `cfg_valid_i` high in IDLE with outstanding>0 → DRAIN. In DRAIN `x_ready_o`=0 and `cfg_ready_o`=0. DRAIN → IDLE when outstanding==0.
  - `cfg_ready_o` is 1 only in IDLE with outstanding==0.
- Weights-loaded flag: set at the end of LOADW and cleared by reset. `x_ready_o` is 0 until it is set.
- LOADW cycle k (k = 0..3): `enW_o` = 1<<k, `W_o` = lane k of the registered weight vector.
- STREAM cycle k: `enX_o`=1, `X_o` = lane k of the registered X vector.
- Outside STREAM, `enX_o`=0 and `X_o`=0. Outside LOADW, `enW_o`=0 and `W_o`=0.
- Credit counter (0..DEPTH) tracks vectors issued but not yet popped from the FIFO:
  - +1 on x handshake.
  - −1 on a y handshake (`y_valid_o` && `y_ready_i`).
  - Both in the same cycle: net 0.
  - `x_ready_o` requires credit<DEPTH.
- Results: `mac_valid_i` pushes `mac_y_i` into the FIFO. Credit guarantees the FIFO is never full on a legal push.
- `mac_valid_i` when no vector is awaiting a result sets `err_o` and the data is dropped. `err_o` is cleared only by reset.
- FP16 values pass through unmodified. The block does no arithmetic on data.

## Timing
- Reset values:
  - state IDLE, FIFO empty, credit 0, weights-loaded 0.
  - All outputs 0 except `cfg_ready_o`=1.
- Reset asserted mid-LOADW or mid-STREAM: the operation is abandoned immediately and the partial vector is lost.
- cfg handshake at edge t: `enW_o`=0001 during cycle t+1, …, 1000 during t+4. GAP is t+5. Earliest `x_ready_o`=1 is t+6.
- x handshake at edge t: `enX_o`=1 during cycles t+1..t+4.
- `x_ready_o` is asserted during cycle t+4 (if credit allows), so a back-to-back vector keeps `enX_o` continuously high, with 4 elements per vector.
- `mac_valid_i` at edge t: `y_valid_o`=1, `y_o` valid from cycle t+1. A simultaneous push and pop in one cycle is legal when occupancy ≥1.
- `y_o` holds stable while `y_valid_o` && !`y_ready_i`.

## Structure
- Shared package `macrow4_pkg`:
  - FP16 width (16) and lane count (4).
  - Packed-vector width (64).
  - FSM state enum (IDLE, LOADW, GAP, STREAM, DRAIN).
- Sub-module `macrow4_resfifo`: DEPTH×16 synchronous FIFO, FWFT, with push, pop, empty, full and count. The credit logic stays in the top level.

## Test plan
- Reset, then cfg `w_vec_i` = {4{16'h8055}}:
  - `enW_o` reads 0001, 0010, 0100, 1000 on consecutive cycles with `W_o`=16'h8055.
  - Then one idle cycle.
  - `x_ready_o` rises 6 cycles after the handshake.
- Two back-to-back X vectors, {4{16'h3155}} then {4{16'h6473}}:
  - `enX_o` is high for 8 consecutive cycles.
  - `X_o` = 3155 ×4, then 6473 ×4.
- DEPTH=2 with `y_ready_i`=0 and 3 X vectors offered:
  - The third vector is stalled (`x_ready_o`=0) after 2 `mac_valid_i` pulses.
  - One pop releases it.
- `cfg_valid_i` while 1 vector is outstanding:
  - `cfg_ready_o` stays 0 and the FSM is in DRAIN.
  - After `mac_valid_i` the FSM returns to IDLE. Once outstanding reaches 0, LOADW starts on the next cfg handshake.
- `mac_valid_i` pulse with nothing outstanding: `err_o`=1 and the FIFO stays empty.
- `reset_n` pulsed low in STREAM cycle 2:
  - All outputs return to reset values asynchronously.
  - `x_ready_o` stays 0 until weights are reloaded.
